// File: rtl/remote_link.sv
// remote_link: remote-control side link engine for the quadcopter command protocol.
// Sends {cmd, data[15:8], data[7:0]} as three back-to-back 8N1 UART bytes on TX,
// then waits for a single response byte on RX. The wait is bounded by TIMEOUT.
// The RX receiver runs continuously and independently of the TX state machine.
// Optional feature: define REMOTE_LINK_RETRY_EN to resend the captured frame once
// after the first response timeout, before timeout_err is raised.
module remote_link #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        busy,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy,
    output logic        timeout_err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;
    localparam logic [1:0] WAIT_RESP = 2'd3;

    localparam logic [11:0] BAUD_M1  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_M1  = 12'(BAUD_DIV / 2 - 1);
    localparam logic [19:0] TOUT_M1  = 20'(TIMEOUT - 1);
    localparam logic [4:0]  FRAME_BITS = 5'd30;

    // TX side
    logic [1:0]  r_state;
    logic [7:0]  r_cmd;
    logic [15:0] r_data;
    logic [29:0] r_frame;
    logic [4:0]  r_nbits;
    logic [11:0] r_baud;
    logic        r_tx;
    logic        r_cmd_sent;
    logic [19:0] r_tcnt;
    logic        r_timeout_err;
`ifdef REMOTE_LINK_RETRY_EN
    logic        r_retried;
`endif

    // RX side
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    logic        r_rx_busy;
    logic [11:0] r_rx_cnt;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_resp;
    logic        r_resp_rdy;

    logic        w_busy;
    logic        w_accept;
    logic        w_rx_sample;
    logic        w_rx_done;

    assign w_busy      = (r_state != IDLE);
    assign w_accept    = send_cmd & ~w_busy;
    assign w_rx_sample = r_rx_busy && (r_rx_cnt == '0);
    // Good stop bit on the final sample: the byte is committed to resp.
    assign w_rx_done   = w_rx_sample && (r_rx_bit == 4'd9) && r_rx_s2;

    assign busy        = w_busy;
    assign TX          = r_tx;
    assign cmd_sent    = r_cmd_sent;
    assign resp        = r_resp;
    assign resp_rdy    = r_resp_rdy;
    assign timeout_err = r_timeout_err;

    // TX state machine: accept, load 30-bit frame, shift it out, wait for response.
    // The whole 3-byte frame is shifted from one register, which gives the
    // back-to-back byte order with no idle gap; the bit is emitted each time the
    // baud counter is zero, and the final zero after the 30th bit ends the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_data        <= '0;
            r_frame       <= '1;
            r_nbits       <= '0;
            r_baud        <= '0;
            r_tx          <= 1'b1;
            r_cmd_sent    <= 1'b1;
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
`ifdef REMOTE_LINK_RETRY_EN
            r_retried     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= LOAD;
                        r_cmd         <= cmd;
                        r_data        <= data;
                        r_cmd_sent    <= 1'b0;
                        r_timeout_err <= 1'b0;
`ifdef REMOTE_LINK_RETRY_EN
                        r_retried     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    r_frame    <= {1'b1, r_data[7:0], 1'b0,
                                   1'b1, r_data[15:8], 1'b0,
                                   1'b1, r_cmd, 1'b0};
                    r_nbits    <= '0;
                    r_baud     <= '0;
                    r_cmd_sent <= 1'b0;
                    r_state    <= SHIFT;
                end
                SHIFT: begin
                    if (r_baud == '0) begin
                        if (r_nbits == FRAME_BITS) begin
                            r_state    <= WAIT_RESP;
                            r_cmd_sent <= 1'b1;
                            r_tcnt     <= '0;
                        end else begin
                            r_tx    <= r_frame[0];
                            r_frame <= {1'b1, r_frame[29:1]};
                            r_nbits <= r_nbits + 5'd1;
                            r_baud  <= BAUD_M1;
                        end
                    end else begin
                        r_baud <= r_baud - 12'd1;
                    end
                end
                WAIT_RESP: begin
                    if (r_tcnt != '1) begin
                        r_tcnt <= r_tcnt + 20'd1;
                    end
                    if (r_resp_rdy) begin
                        r_state <= IDLE;
                    end else if (r_tcnt == TOUT_M1) begin
`ifdef REMOTE_LINK_RETRY_EN
                        if (!r_retried) begin
                            r_retried <= 1'b1;
                            r_state   <= LOAD;
                        end else begin
                            r_timeout_err <= 1'b1;
                            r_state       <= IDLE;
                        end
`else
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for RX plus one extra stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // RX byte receiver: mid-bit sampling, false-start and framing-error rejection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_resp     <= '0;
        end else if (!r_rx_busy) begin
            if (!r_rx_s2 && r_rx_s3) begin
                r_rx_busy <= 1'b1;
                r_rx_cnt  <= HALF_M1;
                r_rx_bit  <= '0;
            end
        end else if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
        end else begin
            r_rx_cnt <= BAUD_M1;
            if (r_rx_bit == 4'd0) begin
                if (r_rx_s2) begin
                    r_rx_busy <= 1'b0;
                end else begin
                    r_rx_bit <= 4'd1;
                end
            end else if (r_rx_bit == 4'd9) begin
                r_rx_busy <= 1'b0;
                if (r_rx_s2) begin
                    r_resp <= r_rx_shift;
                end
            end else begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 4'd1;
            end
        end
    end

    // Response-ready flag: a new byte wins over clear and over a new command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_rdy <= 1'b0;
        end else if (w_rx_done) begin
            r_resp_rdy <= 1'b1;
        end else if (clr_resp_rdy || w_accept) begin
            r_resp_rdy <= 1'b0;
        end
    end

endmodule

// File: doc/remote_link.md
# remote_link

Remote-control side link engine for the quadcopter command protocol. It accepts one command byte plus 16-bit data, serializes them as a 3-byte 8N1 UART frame on `TX`, then waits for the quadcopter's single response byte on `RX`. Response arrival is bounded by a timeout. It sits between the remote-control stimulus/joystick logic and the serial wire that feeds the quad's `UART_comm`, and owns its own bit-level TX/RX.

## Interface
- `BAUD_DIV`, 2604: clocks per UART bit (50 MHz / 19200); must be ≥ 8.
- `TIMEOUT`, 500000: clocks allowed from `cmd_sent` rising to response stop-bit sample.

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd`  in  8  command byte; sampled on accepted `send_cmd`
- `data`  in  16  command data; sampled on accepted `send_cmd`
- `send_cmd`  in  1  one-cycle request to send a frame; ignored when `busy`
- `cmd_sent`  out  1  level; high once the last stop bit completes, low from accept until then
- `busy`  out  1  high from accept until response received or timeout
- `TX`  out  1  serial out, idle high
- `RX`  in  1  serial in, asynchronous, idle high
- `resp`  out  8  last good response byte
- `resp_rdy`  out  1  level; new response valid
- `clr_resp_rdy`  in  1  clears `resp_rdy`
- `timeout_err`  out  1  level; set on response timeout, cleared on next accepted `send_cmd`

## Operation
- Reset values: `TX`=1, `cmd_sent`=1, `busy`=0, `resp`=8'h00, `resp_rdy`=0, `timeout_err`=0. Reset mid-frame aborts immediately and `TX` returns high asynchronously.
- TX FSM states:
  - IDLE → LOAD on `send_cmd & ~busy`.
  - LOAD → SHIFT: capture `{cmd,data}`, byte index=0, clear `cmd_sent`, `timeout_err`, `resp_rdy`.
  - SHIFT sends one 10-bit frame: start 0, 8 data bits LSB first, stop 1.
  - After each stop bit: index 0→1→2 back-to-back with no idle gap, then WAIT_RESP.
  - Byte order: `cmd`, `data[15:8]`, `data[7:0]`.
- WAIT_RESP:
  - Counter starts at 0 as `cmd_sent` rises.
  - `resp_rdy` set → IDLE, `busy` low.
  - Counter reaches `TIMEOUT-1` → set `timeout_err`, go to IDLE (or retry, see Configuration).
- RX path runs continuously and independently of the TX FSM:
  - `RX` passes through a 2-flop synchronizer.
  - Falling edge in RX idle starts a byte.
  - Samples at `BAUD_DIV/2`, then every `BAUD_DIV`.
  - Start bit sampled 1 → false start, return to RX idle.
  - Stop bit sampled 0 → framing error: byte discarded, `resp` and `resp_rdy` unchanged.
- `resp_rdy` set and `clr_resp_rdy` in the same cycle: set wins.
- `send_cmd` while `busy`: ignored, no state change.
- A response arriving outside WAIT_RESP still updates `resp`/`resp_rdy`.

## Timing
- `TX` start bit of byte 0 drives low 2 cycles after the `send_cmd` edge (LOAD takes one cycle).
- Frame length is exactly `30*BAUD_DIV` cycles.
- `cmd_sent` rises on the cycle after the final stop-bit period ends.
- RX latency: `resp_rdy` rises one cycle after the stop-bit sample, i.e. about `9.5*BAUD_DIV + 3` cycles after the `RX` falling edge.
- Bit counter is 12 bits. Timeout counter is 20 bits, and it saturates.

## Configuration
- `REMOTE_LINK_RETRY_EN` defined:
  - The first timeout does not set `timeout_err`. The FSM re-enters LOAD with the captured `cmd`/`data` (no new sampling) and resends once.
  - `cmd_sent` drops for the retry.
  - Second timeout sets `timeout_err`.
  - A retry-taken flag clears on the next accepted `send_cmd`.
- Undefined: the first timeout sets `timeout_err` and returns to IDLE directly; there are no retry registers.

## Test plan
All scenarios use `BAUD_DIV`=16 and `TIMEOUT`=2000.
- `send_cmd` with `cmd`=8'hB7, `data`=16'hB73C → `TX` bytes B7, B7, 3C LSB-first, each with start/stop. `cmd_sent` rises 480+2 cycles after accept.
- Loop `TX` through a quad-side responder that returns 8'hCD → `resp`=8'hCD, `resp_rdy`=1, `busy`=0, `timeout_err`=0. `clr_resp_rdy` then drops `resp_rdy` next cycle.
- No response on `RX` (held high) → `timeout_err`=1 exactly 2000 cycles after `cmd_sent` rises. With `REMOTE_LINK_RETRY_EN`, the frame is sent twice first, then `timeout_err` is set.
- `send_cmd` pulsed mid-frame with `cmd`=8'h00 → ignored; the original frame completes unchanged.
- `RX` byte 8'h67 with stop bit forced 0 → `resp_rdy` stays 0. A good 8'h67 follows → `resp`=8'h67.
- `rst_n` asserted during byte 1 → `TX`=1 immediately, all outputs return to reset values; the next `send_cmd` sends a complete frame.
